// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the arbitrated UART transmitter.
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_W     = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every CLOCK_DIVIDE+1 clocks.
module uart_baud_tick #(
    parameter int CLOCK_DIVIDE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW =
        (CLOCK_DIVIDE > 0) ? $clog2(CLOCK_DIVIDE + 1) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLOCK_DIVIDE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one 8N1 UART TX line.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int CLOCK_DIVIDE = 10,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [DATA_W*NREQ-1:0]     req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic                       grant_valid,
    output logic [$clog2(NREQ)-1:0]    grant_id
);

    localparam int IW = $clog2(NREQ);
    localparam int TW =
        (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST =
        TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    state_t            state;
    logic              tick;
    logic              accept;
    logic              owner_valid;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     sel;
    logic [NREQ-1:0]   pick_vec;
    logic [NREQ-1:0]   owner_vec;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic [DATA_W-1:0] shreg;
    logic              last_q;
    logic [2:0]        bit_idx;
    logic [TW-1:0]     hold_cnt;

    // First valid requester strictly after p, wrapping.
    function automatic logic [IW-1:0] rr_pick(
        input logic [NREQ-1:0] v,
        input logic [IW-1:0]   p
    );
        logic found;
        found   = 1'b0;
        rr_pick = p;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && v[i] &&
                    i == (int'(p) + k) % NREQ) begin
                    rr_pick = IW'(i);
                    found   = 1'b1;
                end
            end
        end
    endfunction

    uart_baud_tick #(
        .CLOCK_DIVIDE(CLOCK_DIVIDE)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .tick (tick)
    );

    always_comb begin
        pick        = rr_pick(req_valid, rr_ptr);
        pick_vec    = '0;
        owner_vec   = '0;
        owner_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pick_vec[i]  = (pick == IW'(i));
            owner_vec[i] = (grant_id == IW'(i));
            if (grant_id == IW'(i)) begin
                owner_valid = req_valid[i];
            end
        end
        req_ready = '0;
        unique case (state)
            ST_IDLE: if (|req_valid) req_ready = pick_vec;
            ST_STOP: if (tick && !last_q && owner_valid)
                         req_ready = owner_vec;
            ST_HOLD: if (owner_valid) req_ready = owner_vec;
            default: ;
        endcase
        // Keep handshakes dead while reset is asserted.
        if (!rst) req_ready = '0;
        accept   = |req_ready;
        sel      = (state == ST_IDLE) ? pick : grant_id;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IW'(i)) begin
                sel_data = req_data[DATA_W*i +: DATA_W];
                sel_last = req_last[i];
            end
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            tx          <= STOP_BIT;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= IW'(NREQ - 1);
            shreg       <= '0;
            last_q      <= 1'b0;
            bit_idx     <= '0;
            hold_cnt    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grant_valid <= 1'b1;
                        grant_id    <= pick;
                        rr_ptr      <= pick;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= STOP_BIT;
                            state <= ST_STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (last_q) begin
                            grant_valid <= 1'b0;
                            state       <= ST_IDLE;
                        end else if (!accept) begin
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!accept) begin
                        if (LOCK_TIMEOUT != 0 &&
                            hold_cnt == T_LAST) begin
                            grant_valid <= 1'b0;
                            state       <= ST_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Any accepted byte starts a fresh frame next cycle.
            if (accept) begin
                shreg  <= sel_data;
                last_q <= sel_last;
                tx     <= START_BIT;
                state  <= ST_START;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a tx-line frame decoder.
module tb_uart_tx_arbiter;

    localparam int CD    = 10;
    localparam int BIT   = CD + 1;
    localparam int FRAME = 10 * BIT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx;
    logic        busy;
    logic        grant_valid;
    logic [0:0]  grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ        (2),
        .CLOCK_DIVIDE(CD),
        .LOCK_TIMEOUT(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [1:0] force_v;
    logic [7:0] force_d;

    int         acc_id[$];
    int         acc_cyc[$];
    int         rx_start[$];
    logic [7:0] rx_q[$];
    int         ready_cnt0, ready_cnt1;
    int         busy_cnt, wave_ok, bad_ready, stop_bad;
    logic       rx_on;
    int         rx_n;
    logic [7:0] rx_sh;
    logic [7:0] exp_byte;
    logic       last_tx;
    logic       r_tx, r_busy, r_gv;
    logic [1:0] r_ready;
    logic [0:0] r_gid;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic wave(input logic [7:0] b,
                                  input int n);
        int k;
        logic [7:0] t;
        k = n / BIT;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        t = b >> (k - 1);
        return t[0];
    endfunction

    function automatic logic [31:0] pack_rx();
        logic [31:0] r;
        r = '0;
        foreach (rx_q[i]) r = (r << 8) | 32'(rx_q[i]);
        return r;
    endfunction

    function automatic logic [31:0] pack_ids();
        logic [31:0] r;
        r = '0;
        foreach (acc_id[i]) r = (r << 4) | 32'(acc_id[i] + 1);
        return r;
    endfunction

    task automatic drive();
        logic [8:0] d0, d1;
        d0 = (q0.size() > 0) ? q0[0] : {1'b0, force_d};
        d1 = (q1.size() > 0) ? q1[0] : {1'b0, force_d};
        req_valid = {q1.size() > 0, q0.size() > 0} | force_v;
        req_data  = {d1[7:0], d0[7:0]};
        req_last  = {d1[8], d0[8]};
    endtask

    task automatic clear_stats();
        acc_id.delete();
        acc_cyc.delete();
        rx_start.delete();
        rx_q.delete();
        ready_cnt0 = 0;
        ready_cnt1 = 0;
        busy_cnt   = 0;
        wave_ok    = 0;
        bad_ready  = 0;
        stop_bad   = 0;
        rx_on      = 1'b0;
        rx_n       = 0;
        rx_sh      = '0;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        cyc++;
        last_tx = tx;
        if (busy) busy_cnt++;
        if ((req_ready & ~req_valid) != 2'b00 ||
            req_ready == 2'b11) bad_ready++;
        if (req_ready[0] && req_valid[0]) begin
            acc_id.push_back(0);
            acc_cyc.push_back(cyc);
            ready_cnt0++;
            if (q0.size() > 0) q0.delete(0);
        end
        if (req_ready[1] && req_valid[1]) begin
            acc_id.push_back(1);
            acc_cyc.push_back(cyc);
            ready_cnt1++;
            if (q1.size() > 0) q1.delete(0);
        end
        if (!rx_on && tx == 1'b0) begin
            rx_on = 1'b1;
            rx_n  = 0;
            rx_start.push_back(cyc);
        end
        if (rx_on) begin
            if (tx === wave(exp_byte, rx_n)) wave_ok++;
            if (rx_n % BIT == BIT / 2) begin
                if (rx_n / BIT >= 1 && rx_n / BIT <= 8) begin
                    rx_sh = {tx, rx_sh[7:1]};
                end else if (rx_n / BIT == 9) begin
                    if (tx !== 1'b1) stop_bad++;
                    rx_q.push_back(rx_sh);
                end
            end
            if (rx_n == FRAME - 1) rx_on = 1'b0;
            else rx_n++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        drive();
        rst = 1'b0;
        #1;
        r_tx    = tx;
        r_busy  = busy;
        r_ready = req_ready;
        r_gv    = grant_valid;
        r_gid   = grant_id;
        repeat (3) begin
            @(negedge clk);
            drive();
        end
        @(posedge clk);
        #1;
        force_v = '0;
        drive();
        rst = 1'b1;
        clear_stats();
    endtask

    function automatic logic [31:0] diff(input int a[$]);
        return (a.size() >= 2) ? 32'(a[1] - a[0]) : 32'hffff_ffff;
    endfunction

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        force_v   = '0;
        force_d   = '0;
        exp_byte  = '0;
        last_tx   = 1'b1;
        clear_stats();

        // reset with both requesters asserting valid
        force_v = 2'b11;
        force_d = 8'h5a;
        reset_dut();
        check("rst_tx", r_tx, 1);
        check("rst_busy", r_busy, 0);
        check("rst_ready", r_ready, 0);
        check("rst_gv", r_gv, 0);
        check("rst_gid", r_gid, 0);

        // single byte 0x36, exact waveform
        reset_dut();
        q0.push_back({1'b1, 8'h36});
        exp_byte = 8'h36;
        run(130);
        check("t1_ready_pulses", ready_cnt0, 1);
        check("t1_rx", pack_rx(), 32'h36);
        check("t1_wave", wave_ok, FRAME);
        check("t1_busy", busy_cnt, FRAME);
        check("t1_latency",
              (rx_start.size() > 0 && acc_cyc.size() > 0) ?
              32'(rx_start[0] - acc_cyc[0]) : 32'hffff_ffff, 1);
        check("t1_gv", grant_valid, 0);
        check("t1_gid", grant_id, 0);
        check("t1_tx_idle", tx, 1);
        check("t1_ready_rules", bad_ready, 0);

        // both valid after reset, twice: rr rotates
        reset_dut();
        q0.push_back({1'b1, 8'ha5});
        q1.push_back({1'b1, 8'h0a});
        run(240);
        q0.push_back({1'b1, 8'ha5});
        q1.push_back({1'b1, 8'h0a});
        run(240);
        check("t2_ids", pack_ids(), 32'h1212);
        check("t2_rx", pack_rx(), 32'ha50aa50a);
        check("t2_ready_rules", bad_ready, 0);

        // two-byte packet holds the lock over req1
        reset_dut();
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b1, 8'h42});
        q1.push_back({1'b1, 8'h0a});
        run(60);
        check("t3_gv_mid", grant_valid, 1);
        check("t3_gid_mid", grant_id, 0);
        run(300);
        check("t3_ids", pack_ids(), 32'h112);
        check("t3_rx", pack_rx(), 32'h41420a);
        check("t3_b2b_gap", diff(rx_start), FRAME);
        check("t3_stop", stop_bad, 0);
        check("t3_gid_end", grant_id, 1);

        // lock timeout releases after 20 hold cycles
        reset_dut();
        q0.push_back({1'b0, 8'h55});
        q1.push_back({1'b1, 8'h0a});
        run(300);
        check("t4_ids", pack_ids(), 32'h12);
        check("t4_rx", pack_rx(), 32'h550a);
        check("t4_accept_gap", diff(acc_cyc), 131);
        check("t4_busy", busy_cnt, 240);
        check("t4_ready_rules", bad_ready, 0);

        // reset in the middle of data bit 3
        reset_dut();
        q0.push_back({1'b1, 8'h00});
        run(50);
        check("t5_pre_tx", last_tx, 0);
        q0.push_back({1'b1, 8'h77});
        q1.push_back({1'b1, 8'h0a});
        reset_dut();
        check("t5_tx", r_tx, 1);
        check("t5_busy", r_busy, 0);
        check("t5_ready", r_ready, 0);
        check("t5_gv", r_gv, 0);
        run(130);
        check("t5_ids", pack_ids(), 32'h12);
        check("t5_rx", pack_rx(), 32'h77);

        // one-cycle valid pulse from a non-owner
        reset_dut();
        q0.push_back({1'b1, 8'hc3});
        exp_byte = 8'hc3;
        run(30);
        force_d = 8'h99;
        force_v = 2'b10;
        run(1);
        force_v = 2'b00;
        run(100);
        check("t6_ready1", ready_cnt1, 0);
        check("t6_rx", pack_rx(), 32'hc3);
        check("t6_wave", wave_ok, FRAME);
        check("t6_ids", pack_ids(), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
